// File: rtl/axis_iq_splitter.sv
// -----------------------------------------------------------------------------
// axis_iq_splitter
//
// Source side of the beamformer channel datapath. Accepts one interleaved I/Q
// AXI stream and emits two lockstep streams, one carrying the real (I) samples
// and one carrying the imaginary (Q) samples. Two input beats pack into one
// output beat. A frame ending on a first-half beat is padded: upper lanes carry
// zero data with zero tkeep.
//
// Ports
//   clock, resetn          clock; synchronous active-low reset
//   s_axis_*               interleaved input stream (tdata lane k: I at
//                          [2*S*k +: S], Q at [2*S*k + S +: S])
//   m_axis_real_*          real output stream (sample j at [S*j +: S])
//   m_axis_imag_*          imag output stream (same layout, Q samples)
//   frame_count            number of input tlast beats accepted (wraps)
//   odd_frame              sticky flag: some frame ended on a first-half beat
// -----------------------------------------------------------------------------
module axis_iq_splitter #(
    parameter int DATA_WIDTH   = 128,
    parameter int SAMPLE_WIDTH = 16
) (
    input  logic                    clock,
    input  logic                    resetn,

    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,

    output logic [DATA_WIDTH-1:0]   m_axis_real_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_real_tkeep,
    output logic                    m_axis_real_tvalid,
    input  logic                    m_axis_real_tready,
    output logic                    m_axis_real_tlast,

    output logic [DATA_WIDTH-1:0]   m_axis_imag_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_imag_tkeep,
    output logic                    m_axis_imag_tvalid,
    input  logic                    m_axis_imag_tready,
    output logic                    m_axis_imag_tlast,

    output logic [31:0]             frame_count,
    output logic                    odd_frame
);

    localparam int CPLX_PER_BEAT = DATA_WIDTH / (2 * SAMPLE_WIDTH);
    localparam int KEEP_WIDTH    = DATA_WIDTH / 8;
    localparam int HALF_WIDTH    = DATA_WIDTH / 2;
    localparam int HALF_KEEP     = KEEP_WIDTH / 2;
    localparam int SAMPLE_BYTES  = SAMPLE_WIDTH / 8;

    localparam logic [1:0] ST_LO    = 2'd0;
    localparam logic [1:0] ST_HI    = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    logic [1:0]            state;
    logic [1:0]            state_next;
    logic                  ready_en;

    // First-half beat, already split into real and imag halves.
    logic [HALF_WIDTH-1:0] lo_real;
    logic [HALF_WIDTH-1:0] lo_imag;
    logic [HALF_KEEP-1:0]  lo_real_keep;
    logic [HALF_KEEP-1:0]  lo_imag_keep;

    // Incoming beat split into halves.
    logic [HALF_WIDTH-1:0] in_real;
    logic [HALF_WIDTH-1:0] in_imag;
    logic [HALF_KEEP-1:0]  in_real_keep;
    logic [HALF_KEEP-1:0]  in_imag_keep;

    logic                  real_pend;
    logic                  imag_pend;
    logic                  out_free;
    logic                  accept;

    logic                  store_lo;
    logic                  load;
    logic [DATA_WIDTH-1:0] load_real;
    logic [DATA_WIDTH-1:0] load_imag;
    logic [KEEP_WIDTH-1:0] load_real_keep;
    logic [KEEP_WIDTH-1:0] load_imag_keep;
    logic                  load_last;

    // De-interleave: lane k contributes sample k of each half.
    // NOTE: every signal driven in always_comb gets a default first so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        in_real      = '0;
        in_imag      = '0;
        in_real_keep = '0;
        in_imag_keep = '0;
        for (int k = 0; k < CPLX_PER_BEAT; k++) begin
            in_real[k*SAMPLE_WIDTH +: SAMPLE_WIDTH] =
                s_axis_tdata[2*k*SAMPLE_WIDTH +: SAMPLE_WIDTH];
            in_imag[k*SAMPLE_WIDTH +: SAMPLE_WIDTH] =
                s_axis_tdata[2*k*SAMPLE_WIDTH + SAMPLE_WIDTH +: SAMPLE_WIDTH];
            in_real_keep[k*SAMPLE_BYTES +: SAMPLE_BYTES] =
                s_axis_tkeep[2*k*SAMPLE_BYTES +: SAMPLE_BYTES];
            in_imag_keep[k*SAMPLE_BYTES +: SAMPLE_BYTES] =
                s_axis_tkeep[2*k*SAMPLE_BYTES + SAMPLE_BYTES +: SAMPLE_BYTES];
        end
    end

    // The output register can take a new beat this edge if each stream is
    // either empty or draining now.
    assign out_free = (!real_pend || m_axis_real_tready) &&
                      (!imag_pend || m_axis_imag_tready);

    // Input ready never looks at tvalid/tlast. ready_en holds it low for the
    // cycle that follows reset.
    assign s_axis_tready = ready_en &&
                           ((state == ST_LO) || ((state == ST_HI) && out_free));
    assign accept        = s_axis_tvalid && s_axis_tready;

    always_comb begin
        state_next     = state;
        store_lo       = 1'b0;
        load           = 1'b0;
        load_real      = '0;
        load_imag      = '0;
        load_real_keep = '0;
        load_imag_keep = '0;
        load_last      = 1'b0;
        case (state)
            ST_LO: begin
                if (accept) begin
                    store_lo = 1'b1;
                    if (!s_axis_tlast) begin
                        state_next = ST_HI;
                    end else if (out_free) begin
                        // Odd-length frame and room to emit: pad straight
                        // from the incoming beat.
                        load           = 1'b1;
                        load_real      = {{HALF_WIDTH{1'b0}}, in_real};
                        load_imag      = {{HALF_WIDTH{1'b0}}, in_imag};
                        load_real_keep = {{HALF_KEEP{1'b0}}, in_real_keep};
                        load_imag_keep = {{HALF_KEEP{1'b0}}, in_imag_keep};
                        load_last      = 1'b1;
                    end else begin
                        state_next = ST_FLUSH;
                    end
                end
            end
            ST_HI: begin
                if (accept) begin
                    load           = 1'b1;
                    load_real      = {in_real, lo_real};
                    load_imag      = {in_imag, lo_imag};
                    load_real_keep = {in_real_keep, lo_real_keep};
                    load_imag_keep = {in_imag_keep, lo_imag_keep};
                    load_last      = s_axis_tlast;
                    state_next     = ST_LO;
                end
            end
            ST_FLUSH: begin
                if (out_free) begin
                    load           = 1'b1;
                    load_real      = {{HALF_WIDTH{1'b0}}, lo_real};
                    load_imag      = {{HALF_WIDTH{1'b0}}, lo_imag};
                    load_real_keep = {{HALF_KEEP{1'b0}}, lo_real_keep};
                    load_imag_keep = {{HALF_KEEP{1'b0}}, lo_imag_keep};
                    load_last      = 1'b1;
                    state_next     = ST_LO;
                end
            end
            default: state_next = ST_LO;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            // NOTE: the data registers are reset as well, both because the
            // outputs must read zero out of reset and so no half-beat from
            // an interrupted frame can leak into the next one.
            state              <= ST_LO;
            ready_en           <= 1'b0;
            lo_real            <= '0;
            lo_imag            <= '0;
            lo_real_keep       <= '0;
            lo_imag_keep       <= '0;
            real_pend          <= 1'b0;
            imag_pend          <= 1'b0;
            m_axis_real_tdata  <= '0;
            m_axis_imag_tdata  <= '0;
            m_axis_real_tkeep  <= '0;
            m_axis_imag_tkeep  <= '0;
            m_axis_real_tlast  <= 1'b0;
            m_axis_imag_tlast  <= 1'b0;
            frame_count        <= '0;
            odd_frame          <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            state    <= state_next;

            if (store_lo) begin
                lo_real      <= in_real;
                lo_imag      <= in_imag;
                lo_real_keep <= in_real_keep;
                lo_imag_keep <= in_imag_keep;
            end

            if (load) begin
                m_axis_real_tdata <= load_real;
                m_axis_imag_tdata <= load_imag;
                m_axis_real_tkeep <= load_real_keep;
                m_axis_imag_tkeep <= load_imag_keep;
                m_axis_real_tlast <= load_last;
                m_axis_imag_tlast <= load_last;
                real_pend         <= 1'b1;
                imag_pend         <= 1'b1;
            end else begin
                // Each stream drains on its own handshake; a stream that has
                // already been taken stays invalid until the next load.
                if (real_pend && m_axis_real_tready) real_pend <= 1'b0;
                if (imag_pend && m_axis_imag_tready) imag_pend <= 1'b0;
            end

            if (accept && s_axis_tlast) begin
                frame_count <= frame_count + 32'd1;
                if (state == ST_LO) odd_frame <= 1'b1;
            end
        end
    end

    assign m_axis_real_tvalid = real_pend;
    assign m_axis_imag_tvalid = imag_pend;

endmodule

// File: tb/tb_axis_iq_splitter.sv
// -----------------------------------------------------------------------------
// tb_axis_iq_splitter
//
// Directed bench for axis_iq_splitter. Inputs and downstream readies change on
// the falling edge; a monitor samples 2 time units later and records every
// handshake that will occur on the next rising edge. Expected output beats are
// derived from the input frame description (sample values base+index).
// -----------------------------------------------------------------------------
module tb_axis_iq_splitter;

    typedef struct {
        logic [127:0] data;
        logic [15:0]  keep;
        logic         last;
    } beat_t;

    logic         clock = 1'b0;
    logic         resetn;
    logic [127:0] s_axis_tdata;
    logic [15:0]  s_axis_tkeep;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic         s_axis_tlast;
    logic [127:0] m_axis_real_tdata;
    logic [15:0]  m_axis_real_tkeep;
    logic         m_axis_real_tvalid;
    logic         m_axis_real_tready;
    logic         m_axis_real_tlast;
    logic [127:0] m_axis_imag_tdata;
    logic [15:0]  m_axis_imag_tkeep;
    logic         m_axis_imag_tvalid;
    logic         m_axis_imag_tready;
    logic         m_axis_imag_tlast;
    logic [31:0]  frame_count;
    logic         odd_frame;

    int checks   = 0;
    int failures = 0;
    int in_hs    = 0;
    int real_hs  = 0;
    int imag_hs  = 0;
    int stalls   = 0;

    beat_t real_got[$];
    beat_t imag_got[$];
    beat_t real_exp[$];
    beat_t imag_exp[$];

    always #5 clock = ~clock;

    axis_iq_splitter dut (
        .clock              (clock),
        .resetn             (resetn),
        .s_axis_tdata       (s_axis_tdata),
        .s_axis_tkeep       (s_axis_tkeep),
        .s_axis_tvalid      (s_axis_tvalid),
        .s_axis_tready      (s_axis_tready),
        .s_axis_tlast       (s_axis_tlast),
        .m_axis_real_tdata  (m_axis_real_tdata),
        .m_axis_real_tkeep  (m_axis_real_tkeep),
        .m_axis_real_tvalid (m_axis_real_tvalid),
        .m_axis_real_tready (m_axis_real_tready),
        .m_axis_real_tlast  (m_axis_real_tlast),
        .m_axis_imag_tdata  (m_axis_imag_tdata),
        .m_axis_imag_tkeep  (m_axis_imag_tkeep),
        .m_axis_imag_tvalid (m_axis_imag_tvalid),
        .m_axis_imag_tready (m_axis_imag_tready),
        .m_axis_imag_tlast  (m_axis_imag_tlast),
        .frame_count        (frame_count),
        .odd_frame          (odd_frame)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Records handshakes that will complete on the coming rising edge.
    always @(negedge clock) begin
        #2;
        if (resetn) begin
            if (s_axis_tvalid && s_axis_tready) in_hs++;
            if (m_axis_real_tvalid && m_axis_real_tready) begin
                real_got.push_back('{m_axis_real_tdata, m_axis_real_tkeep, m_axis_real_tlast});
                real_hs++;
            end
            if (m_axis_imag_tvalid && m_axis_imag_tready) begin
                imag_got.push_back('{m_axis_imag_tdata, m_axis_imag_tkeep, m_axis_imag_tlast});
                imag_hs++;
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after acceptance
    // with the beat still driven (caller replaces it or drops tvalid).
    task automatic send_beat(input logic [127:0] d, input logic [15:0] k, input logic last);
        int waited = 0;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        #2;
        while (!s_axis_tready && waited < 200) begin
            @(negedge clock);
            #2;
            waited++;
            stalls++;
        end
        check("accept_timeout", 128'(waited >= 200), 128'd0);
        @(negedge clock);
    endtask

    // Frame of n beats: lane k of beat b carries I=base_i+4b+k, Q=base_q+4b+k.
    // Output beat m therefore carries r_j=base_i+8m+j for the lanes present.
    task automatic send_frame(input int n, input logic [15:0] base_i,
                              input logic [15:0] base_q, input logic [15:0] last_keep);
        logic [15:0] keeps[64];
        for (int b = 0; b < n; b++) begin
            logic [127:0] d;
            for (int k = 0; k < 4; k++) begin
                d[32*k +: 16]    = base_i + 16'(4*b + k);
                d[32*k+16 +: 16] = base_q + 16'(4*b + k);
            end
            keeps[b] = (b == n-1) ? last_keep : 16'hFFFF;
            send_beat(d, keeps[b], b == n-1);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        for (int m = 0; m < (n+1)/2; m++) begin
            beat_t r;
            beat_t q;
            r = '{128'd0, 16'd0, m == (n+1)/2 - 1};
            q = r;
            for (int j = 0; j < 8; j++) begin
                int b = 2*m + j/4;
                int k = j % 4;
                if (b < n) begin
                    r.data[16*j +: 16] = base_i + 16'(8*m + j);
                    q.data[16*j +: 16] = base_q + 16'(8*m + j);
                    r.keep[2*j +: 2]   = keeps[b][4*k +: 2];
                    q.keep[2*j +: 2]   = keeps[b][4*k+2 +: 2];
                end
            end
            real_exp.push_back(r);
            imag_exp.push_back(q);
        end
    endtask

    task automatic compare_outputs(input string tag);
        int waited = 0;
        int n;
        @(negedge clock);
        #2;
        while ((m_axis_real_tvalid || m_axis_imag_tvalid) && waited < 100) begin
            @(negedge clock);
            #2;
            waited++;
        end
        check({tag, "_drain_timeout"}, 128'(waited >= 100), 128'd0);
        check({tag, "_real_count"}, 128'(real_got.size()), 128'(real_exp.size()));
        check({tag, "_imag_count"}, 128'(imag_got.size()), 128'(imag_exp.size()));
        n = (real_got.size() < real_exp.size()) ? real_got.size() : real_exp.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_real_data%0d", tag, i), real_got[i].data, real_exp[i].data);
            check($sformatf("%s_real_keep%0d", tag, i), 128'(real_got[i].keep), 128'(real_exp[i].keep));
            check($sformatf("%s_real_last%0d", tag, i), 128'(real_got[i].last), 128'(real_exp[i].last));
        end
        n = (imag_got.size() < imag_exp.size()) ? imag_got.size() : imag_exp.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_imag_data%0d", tag, i), imag_got[i].data, imag_exp[i].data);
            check($sformatf("%s_imag_keep%0d", tag, i), 128'(imag_got[i].keep), 128'(imag_exp[i].keep));
            check($sformatf("%s_imag_last%0d", tag, i), 128'(imag_got[i].last), 128'(imag_exp[i].last));
        end
        real_got.delete();
        imag_got.delete();
        real_exp.delete();
        imag_exp.delete();
    endtask

    initial begin
        int s0;
        int r0;
        int i0;
        int q0;
        resetn             = 1'b0;
        s_axis_tdata       = '0;
        s_axis_tkeep       = '0;
        s_axis_tvalid      = 1'b0;
        s_axis_tlast       = 1'b0;
        m_axis_real_tready = 1'b1;
        m_axis_imag_tready = 1'b1;

        // Reset state
        repeat (3) @(negedge clock);
        #2;
        check("rst_real_valid", 128'(m_axis_real_tvalid), 128'd0);
        check("rst_imag_valid", 128'(m_axis_imag_tvalid), 128'd0);
        check("rst_s_ready",    128'(s_axis_tready), 128'd0);
        check("rst_real_data",  m_axis_real_tdata, 128'd0);
        check("rst_frame_count", 128'(frame_count), 128'd0);
        check("rst_odd_frame",  128'(odd_frame), 128'd0);
        resetn = 1'b1;
        @(negedge clock);

        // 1: two-beat frame; output valid right after the second beat's edge
        send_frame(2, 16'h1000, 16'h2000, 16'hFFFF);
        #1;
        check("t1_latency_real_valid", 128'(m_axis_real_tvalid), 128'd1);
        check("t1_latency_imag_valid", 128'(m_axis_imag_tvalid), 128'd1);
        check("t1_real_tdata", m_axis_real_tdata,
              128'h1007_1006_1005_1004_1003_1002_1001_1000);
        compare_outputs("t1");
        check("t1_frame_count", 128'(frame_count), 128'd1);
        check("t1_odd_frame", 128'(odd_frame), 128'd0);

        // 2: three-beat frame, padded second output beat
        @(negedge clock);
        send_frame(3, 16'h1100, 16'h2100, 16'hFFFF);
        compare_outputs("t2");
        check("t2_frame_count", 128'(frame_count), 128'd2);
        check("t2_odd_frame", 128'(odd_frame), 128'd1);

        // 3: 64-beat frame at full rate, input never stalls
        @(negedge clock);
        s0 = stalls;
        send_frame(64, 16'h3000, 16'h4000, 16'hFFFF);
        check("t3_input_stalls", 128'(stalls - s0), 128'd0);
        compare_outputs("t3");

        // 4: imag stalled for 5 cycles during a 16-beat frame
        @(negedge clock);
        m_axis_imag_tready = 1'b0;
        r0 = real_hs;
        i0 = in_hs;
        q0 = imag_hs;
        fork
            send_frame(16, 16'h5000, 16'h6000, 16'hFFFF);
            begin
                repeat (5) @(negedge clock);
                check("t4_real_hs_during_stall", 128'(real_hs - r0), 128'd1);
                check("t4_imag_hs_during_stall", 128'(imag_hs - q0), 128'd0);
                check("t4_in_hs_during_stall", 128'(in_hs - i0), 128'd3);
                check("t4_real_valid_after_take", 128'(m_axis_real_tvalid), 128'd0);
                check("t4_imag_valid_held", 128'(m_axis_imag_tvalid), 128'd1);
                check("t4_imag_data_held", m_axis_imag_tdata,
                      128'h6007_6006_6005_6004_6003_6002_6001_6000);
                check("t4_s_ready_low", 128'(s_axis_tready), 128'd0);
                m_axis_imag_tready = 1'b1;
            end
        join
        compare_outputs("t4");
        check("t4_frame_count", 128'(frame_count), 128'd4);

        // 5: odd tlast while the output is stalled -> flush path
        @(negedge clock);
        m_axis_real_tready = 1'b0;
        m_axis_imag_tready = 1'b0;
        send_frame(3, 16'h7000, 16'h7800, 16'h003F);
        #2;
        check("t5_flush_ready_low", 128'(s_axis_tready), 128'd0);
        @(negedge clock);
        m_axis_real_tready = 1'b1;
        @(negedge clock);
        #2;
        check("t5_ready_low_imag_pending", 128'(s_axis_tready), 128'd0);
        check("t5_real_taken", 128'(m_axis_real_tvalid), 128'd0);
        @(negedge clock);
        m_axis_imag_tready = 1'b1;
        @(negedge clock);
        #2;
        check("t5_ready_back", 128'(s_axis_tready), 128'd1);
        check("t5_pad_real_valid", 128'(m_axis_real_tvalid), 128'd1);
        check("t5_pad_real_keep", 128'(m_axis_real_tkeep), 128'h000F);
        check("t5_pad_imag_keep", 128'(m_axis_imag_tkeep), 128'h0003);
        check("t5_pad_real_data", m_axis_real_tdata,
              128'h0000_0000_0000_0000_700B_700A_7009_7008);
        compare_outputs("t5");
        check("t5_frame_count", 128'(frame_count), 128'd5);

        // 6: reset after a first-half beat drops it
        @(negedge clock);
        send_beat(128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF, 16'hFFFF, 1'b0);
        s_axis_tvalid = 1'b0;
        resetn = 1'b0;
        @(negedge clock);
        #2;
        check("t6_real_valid", 128'(m_axis_real_tvalid), 128'd0);
        check("t6_imag_valid", 128'(m_axis_imag_tvalid), 128'd0);
        check("t6_frame_count_rst", 128'(frame_count), 128'd0);
        check("t6_odd_frame_rst", 128'(odd_frame), 128'd0);
        resetn = 1'b1;
        @(negedge clock);
        send_frame(2, 16'h0A00, 16'h0B00, 16'hFFFF);
        compare_outputs("t6");
        check("t6_frame_count", 128'(frame_count), 128'd1);
        check("t6_odd_frame", 128'(odd_frame), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
